// File: rtl/dmem_lsu.sv
// Byte-addressed RV32 data memory with load/store unit semantics for the MEM stage.
// Valid/ready request channel, configurable load latency, self-clearing init after reset.
module dmem_lsu #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err
);

   localparam int IDXW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {INIT, IDLE, BUSY} state_t;

   state_t          state;
   logic [IDXW-1:0] clr_cnt;
   logic [1:0]      lat_cnt;
   logic [31:0]     hold_data;
   logic            hold_err;
   logic [31:0]     mem [DEPTH_WORDS];

   logic            accept;
   logic [IDXW-1:0] idx;
   logic [1:0]      lane;
   logic            in_range;
   logic            f3_ok;
   logic            misal;
   logic            is_byte;
   logic            is_half;
   logic            unsigned_ld;
   logic            err;
   logic [31:0]     rd_word;
   logic [31:0]     rd_shift;
   logic [31:0]     load_val;
   logic [3:0]      wmask;
   logic [31:0]     wdata_sh;

   assign accept = req_valid && req_ready;
   assign idx    = req_addr[IDXW+1:2];
   assign lane   = req_addr[1:0];

   // Any set address bit above the word index means the request is out of range.
   generate
      if (ADDR_WIDTH - 2 > IDXW) begin : g_range
         assign in_range = ~|req_addr[ADDR_WIDTH-1:IDXW+2];
      end else begin : g_full
         assign in_range = 1'b1;
      end
   endgenerate

   always_comb begin
      f3_ok       = 1'b1;
      misal       = 1'b0;
      is_byte     = 1'b0;
      is_half     = 1'b0;
      unsigned_ld = 1'b0;
      case (req_funct3)
         3'b000: is_byte = 1'b1;
         3'b001: begin
            is_half = 1'b1;
            misal   = lane[0];
         end
         3'b010: misal = |lane;
         3'b100: begin
            is_byte     = 1'b1;
            unsigned_ld = 1'b1;
            f3_ok       = !req_we;
         end
         3'b101: begin
            is_half     = 1'b1;
            unsigned_ld = 1'b1;
            misal       = lane[0];
            f3_ok       = !req_we;
         end
         default: f3_ok = 1'b0;
      endcase
      err = !f3_ok || misal || !in_range;

      rd_word  = mem[idx];
      rd_shift = rd_word >> {lane, 3'b000};
      if (is_byte)
         load_val = {{24{!unsigned_ld && rd_shift[7]}}, rd_shift[7:0]};
      else if (is_half)
         load_val = {{16{!unsigned_ld && rd_shift[15]}}, rd_shift[15:0]};
      else
         load_val = rd_word;

      if (is_byte)
         wmask = 4'b0001 << lane;
      else if (is_half)
         wmask = lane[1] ? 4'b1100 : 4'b0011;
      else
         wmask = 4'b1111;
      wdata_sh = req_wdata << {lane, 3'b000};
   end

   // Storage carries no reset; the INIT sweep zeroes it one word per cycle.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[clr_cnt] <= '0;
      end else if (accept && req_we && !err) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (wmask[b])
               mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         clr_cnt   <= '0;
         lat_cnt   <= '0;
         hold_data <= '0;
         hold_err  <= 1'b0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            INIT: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == IDXW'(DEPTH_WORDS - 1)) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end
            end
            IDLE: begin
               if (accept) begin
                  state     <= BUSY;
                  req_ready <= 1'b0;
                  hold_err  <= err;
                  hold_data <= (req_we || err) ? '0 : load_val;
                  lat_cnt   <= (req_we || err) ? 2'd0 : 2'(READ_LATENCY - 1);
               end
            end
            BUSY: begin
               if (lat_cnt == 2'd0) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= hold_data;
                  rsp_err   <= hold_err;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed and random requests checked every cycle against a
// transaction-level model (word array plus one pending response with a due cycle).
module tb_dmem_lsu;

   localparam int DEPTH = 16;
   localparam int LAT   = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int total = 0;
   int bad   = 0;

   logic [31:0] mm [DEPTH];
   int          edges = 0;
   bit          have_pend = 0;
   int          due = 0;
   logic [31:0] pend_data = '0;
   logic        pend_err = 1'b0;
   logic [31:0] last_rdata = '0;

   dmem_lsu #(
      .ADDR_WIDTH  (32),
      .DEPTH_WORDS (DEPTH),
      .READ_LATENCY(LAT)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_funct3(req_funct3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit model_ready();
      return (edges >= DEPTH) && !have_pend;
   endfunction

   task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, output logic e, output logic [31:0] r);
      int unsigned idx, lane, sz;
      bit sgn;
      logic [31:0] w, mask;
      idx  = a >> 2;
      lane = a % 4;
      sz   = 0;
      sgn  = 0;
      e    = 1'b0;
      r    = '0;
      case (f3)
         3'd0: begin sz = 1; sgn = 1; end
         3'd1: begin sz = 2; sgn = 1; end
         3'd2: sz = 4;
         3'd4: if (!we) sz = 1;
         3'd5: if (!we) sz = 2;
         default: sz = 0;
      endcase
      if (sz == 0) e = 1'b1;
      else if (lane % sz != 0) e = 1'b1;
      else if (idx >= DEPTH) e = 1'b1;
      if (!e) begin
         if (we) begin
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 1) << (8 * lane);
            mm[idx] = (mm[idx] & ~mask) | ((wd << (8 * lane)) & mask);
         end else begin
            w = mm[idx] >> (8 * lane);
            if (sz == 1) begin
               r = w % 256;
               if (sgn && r >= 128) r = r + 32'hFFFF_FF00;
            end else if (sz == 2) begin
               r = w % 65536;
               if (sgn && r >= 32768) r = r + 32'hFFFF_0000;
            end else begin
               r = w;
            end
         end
      end
   endtask

   // Called at a falling edge; drives one cycle of request and checks the result.
   task automatic step(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
      bit acc;
      logic e;
      logic [31:0] r;
      bit exp_v;
      req_valid  = v;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      acc = v && model_ready();
      e = 1'b0;
      r = '0;
      if (acc) model_access(we, f3, a, wd, e, r);
      @(posedge clk);
      edges++;
      if (acc) begin
         have_pend = 1;
         due       = edges + ((!we && !e) ? LAT : 1);
         pend_data = r;
         pend_err  = e;
      end
      @(negedge clk);
      exp_v = have_pend && (due == edges);
      chk("rsp_valid", rsp_valid, exp_v);
      if (exp_v) begin
         last_rdata = pend_data;
         chk("rsp_err", rsp_err, pend_err);
         have_pend = 0;
      end
      chk("rsp_rdata", rsp_rdata, last_rdata);
      chk("req_ready", req_ready, model_ready());
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_r, input logic exp_e);
      step(1'b1, we, f3, a, wd);
      for (int i = 0; i < 8 && rsp_valid !== 1'b1; i++) idle();
      chk({tag, "_seen"}, rsp_valid, 1);
      chk(tag, rsp_rdata, exp_r);
      chk({tag, "_err"}, rsp_err, exp_e);
   endtask

   task automatic do_reset();
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_err", rsp_err, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_hold_valid", rsp_valid, 0);
         chk("rst_hold_ready", req_ready, 0);
      end
      rst_n      = 1'b1;
      edges      = 0;
      have_pend  = 0;
      last_rdata = '0;
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
   endtask

   initial begin
      logic        rv, rwe;
      logic [2:0]  rf3;
      logic [31:0] ra, rwd;

      #2;
      do_reset();
      for (int i = 0; i < DEPTH + 4; i++) idle();
      for (int a = 0; a < 4 * DEPTH; a += 4) txn("init_lw", 1'b0, 3'd2, 32'(a), 32'h0, 32'h0, 1'b0);

      txn("sw_10",   1'b1, 3'd2, 32'h10, 32'h80F0_7F01, 32'h0, 1'b0);
      txn("lb_10",   1'b0, 3'd0, 32'h10, 32'h0, 32'h0000_0001, 1'b0);
      txn("lb_13",   1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0);
      txn("lbu_13",  1'b0, 3'd4, 32'h13, 32'h0, 32'h0000_0080, 1'b0);
      txn("lh_12",   1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF_80F0, 1'b0);
      txn("lhu_12",  1'b0, 3'd5, 32'h12, 32'h0, 32'h0000_80F0, 1'b0);
      txn("sb_11",   1'b1, 3'd0, 32'h11, 32'h0000_00AA, 32'h0, 1'b0);
      txn("lw_10",   1'b0, 3'd2, 32'h10, 32'h0, 32'h80F0_AA01, 1'b0);
      txn("sh_16",   1'b1, 3'd1, 32'h16, 32'hCAFE_BEEF, 32'h0, 1'b0);
      txn("lw_14",   1'b0, 3'd2, 32'h14, 32'h0, 32'hBEEF_0000, 1'b0);

      txn("lw_mis",  1'b0, 3'd2, 32'h02, 32'h0, 32'h0, 1'b1);
      txn("sh_mis",  1'b1, 3'd1, 32'h05, 32'h1234, 32'h0, 1'b1);
      txn("f3_011",  1'b0, 3'd3, 32'h00, 32'h0, 32'h0, 1'b1);
      txn("sbu_ill", 1'b1, 3'd4, 32'h00, 32'hFF, 32'h0, 1'b1);
      txn("sw_0",    1'b1, 3'd2, 32'h00, 32'h1234_5678, 32'h0, 1'b0);
      txn("sw_oor",  1'b1, 3'd2, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b1);
      txn("sw_hi",   1'b1, 3'd2, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0, 1'b1);
      txn("lw_0",    1'b0, 3'd2, 32'h00, 32'h0, 32'h1234_5678, 1'b0);

      // Load latency, then a store issued during the response cycle.
      step(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
      idle();
      idle();
      chk("lat_ready_low", req_ready, 0);
      idle();
      chk("lat_valid", rsp_valid, 1);
      chk("lat_data", rsp_rdata, 32'h80F0_AA01);
      step(1'b1, 1'b1, 3'd2, 32'h18, 32'h0BAD_F00D);
      idle();
      chk("b2b_store_valid", rsp_valid, 1);
      txn("lw_18", 1'b0, 3'd2, 32'h18, 32'h0, 32'h0BAD_F00D, 1'b0);

      // Requests held valid continuously with changing fields.
      for (int i = 0; i < 60; i++) begin
         rwe = 1'($urandom_range(0, 1));
         rf3 = 3'($urandom_range(0, 5));
         ra  = 32'($urandom_range(0, 4 * DEPTH + 7));
         rwd = $urandom;
         step(1'b1, rwe, rf3, ra, rwd);
      end

      for (int i = 0; i < 400; i++) begin
         rv  = ($urandom_range(0, 9) < 7);
         rwe = 1'($urandom_range(0, 1));
         rf3 = 3'($urandom_range(0, 7));
         ra  = 32'($urandom_range(0, 4 * DEPTH + 15));
         if ($urandom_range(0, 15) == 0) ra = ra | 32'h8000_0000;
         rwd = $urandom;
         step(rv, rwe, rf3, ra, rwd);
      end
      for (int i = 0; i < 6; i++) idle();

      for (int a = 0; a < 4 * DEPTH; a += 4) txn("fill", 1'b1, 3'd2, 32'(a), 32'hA5A5_0000 + 32'(a), 32'h0, 1'b0);
      step(1'b1, 1'b0, 3'd2, 32'h08, 32'h0);
      idle();
      do_reset();
      for (int i = 0; i < DEPTH + 2; i++) idle();
      for (int a = 0; a < 4 * DEPTH; a += 4) txn("reinit_lw", 1'b0, 3'd2, 32'(a), 32'h0, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
